// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_FIXUP = 2'b10
    } muldiv_state_t;

    // Signed ops take absolute values up front and correct signs in FIXUP.
    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the engine: shift-add for multiply, restoring
// shift-subtract for divide. The accumulator holds {upper, lower} halves;
// for divide the upper half is the partial remainder and the lower half
// shifts the dividend out while the quotient bits shift in.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] top;
    logic [WIDTH:0] diff;

    // Both candidate results are formed every cycle; is_div picks one.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        top      = acc[2*WIDTH-1:WIDTH-1];
        diff     = top - {1'b0, opnd};
        acc_next = acc;
        if (is_div) begin
            // The partial remainder stays below the divisor, so a set top
            // bit of diff can only mean the trial subtraction went negative.
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum, acc[WIDTH-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO pair.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting; serves MTHI/MTLO writes, latches operands on start
//   S_CALC  | WIDTH iterations of shift-add or shift-subtract
//   S_FIXUP | sign correction, HI/LO commit, done pulse issued
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mf_req,
    input  logic             mt_we,
    input  logic             hl_sel,
    input  logic [WIDTH-1:0] mt_data,
    output logic [WIDTH-1:0] mf_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    muldiv_state_t      state_q, state_d;
    muldiv_op_t         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    muldiv_op_t         op_in;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               calc_div;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (calc_div),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_acc)
    );

    // Operand conditioning at start, and sign correction of the finished result.
    always_comb begin
        op_in    = muldiv_op_t'(op);
        sign_a   = op_is_signed(op_in) & a[WIDTH-1];
        sign_b   = op_is_signed(op_in) & b[WIDTH-1];
        abs_a    = sign_a ? (WIDTH'(0) - a) : a;
        abs_b    = sign_b ? (WIDTH'(0) - b) : b;
        calc_div = op_is_div(op_q);
        prod_fix = neg_res_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
        quo_fix  = neg_res_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH])
                             : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state, iteration and HI/LO update.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op_in;
                    cnt_d     = '0;
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    if (op_is_div(op_in)) begin
                        acc_d  = {{WIDTH{1'b0}}, abs_a};
                        opnd_d = abs_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, abs_b};
                        opnd_d = abs_a;
                    end
                    state_d = S_CALC;
                end else if (mt_we) begin
                    if (hl_sel) begin
                        hi_d = mt_data;
                    end else begin
                        lo_d = mt_data;
                    end
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIXUP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIXUP: begin
                if (calc_div) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                dz_d    = calc_div & (opnd_q == '0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    // Core-facing outputs.
    always_comb begin
        busy     = (state_q != S_IDLE);
        stall    = busy & (start | mf_req | mt_we);
        mf_data  = hl_sel ? hi_q : lo_q;
        done     = done_q;
        div_zero = dz_q;
    end

endmodule
